// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings used by every slave on the interconnect.
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb3lite_sram_ws_pkg.sv
// Types and byte-lane helpers for the wait-state SRAM slave (sized for the widest 128-bit bus).
package ahb3lite_sram_ws_pkg;
  typedef enum logic [1:0] {IDLE, RWAIT, ERR1, ERR2} state_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  addr;
    logic [15:0]  be;
    logic [127:0] data;
  } wbuf_t;

  // Lane mask of 2**size bytes starting at the byte offset within the bus word.
  function automatic logic [15:0] gen_be(input logic [2:0] size, input logic [3:0] offs,
                                         input int unsigned lanes);
    logic [31:0] m;
    logic [3:0]  o;
    m = (32'h1 << (32'd1 << size)) - 32'h1;
    o = offs & 4'(lanes - 1);
    m = m << o;
    return m[15:0];
  endfunction

  function automatic logic [127:0] merge_bytes(input logic [127:0] old_d, input logic [127:0] new_d,
                                               input logic [15:0] be);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = be[i] ? new_d[i*8 +: 8] : old_d[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/ahb3lite_sram_ws_if.sv
// AHB3-Lite slave-port bundle (everything except clock and reset).
interface ahb3lite_sram_ws_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
                  input  HRDATA, HREADYOUT, HRESP);
  modport slave  (input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
                  output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/rl_ram_1r1w.sv
// Generic one-read/one-write RAM model: registered read, byte-enabled write, read-before-write.
module rl_ram_1r1w #(
  parameter int    DEPTH      = 256,
  parameter int    ABITS      = 8,
  parameter int    DBITS      = 32,
  parameter string TECHNOLOGY = "GENERIC",
  parameter string INIT_FILE  = ""
) (
  input  logic               clk,
  input  logic [ABITS-1:0]   waddr,
  input  logic [DBITS-1:0]   wdata,
  input  logic               we,
  input  logic [DBITS/8-1:0] be,
  input  logic [ABITS-1:0]   raddr,
  input  logic               re,
  output logic [DBITS-1:0]   rdata
);
  // Macro selection and preload live in the technology-specific variants of this wrapper.
  localparam bit unused_params = (TECHNOLOGY != "") || (INIT_FILE != "");

  logic [DBITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < DBITS/8; i++)
      if (we && be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
  end
endmodule

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave with programmable read wait states, ERROR responses and write forwarding.
module ahb3lite_sram_ws
  import ahb3lite_pkg::*;
  import ahb3lite_sram_ws_pkg::*;
#(
  parameter int    MEM_DEPTH   = 256,
  parameter int    HADDR_SIZE  = 32,
  parameter int    HDATA_SIZE  = 32,
  parameter int    WAIT_STATES = 0,
  parameter string TECHNOLOGY  = "GENERIC",
  parameter string INIT_FILE   = ""
) (
  input logic HCLK,
  input logic HRESET,
  ahb3lite_sram_ws_if.slave bus
);
  localparam int         BE_W     = HDATA_SIZE / 8;
  localparam int         AW_LSB   = $clog2(BE_W);
  localparam int         RAW      = $clog2(MEM_DEPTH);
  localparam int         WA_W     = HADDR_SIZE - AW_LSB;
  localparam logic [2:0] MAX_SIZE = 3'(AW_LSB);
  localparam logic [2:0] WS_M1    = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q;
  logic                  wr_p1, rd_done_p1;
  logic [RAW-1:0]        waddr_p1, rd_addr_p1;
  logic [BE_W-1:0]       be_p1;
  logic [HDATA_SIZE-1:0] hrdata_q, ram_q, rd_data;
  wbuf_t                 wbuf;

  logic            unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HPROT};

  // Address phase: acceptance, range/size check, byte enables
  logic [WA_W-1:0] word_addr;
  logic            accept, err, rd_go, wr_go, err_go;
  logic [15:0]     be_full;

  assign word_addr = bus.HADDR[HADDR_SIZE-1:AW_LSB];
  assign accept    = bus.HSEL && bus.HREADY &&
                     (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
  assign err       = (word_addr >= WA_W'(MEM_DEPTH)) || (bus.HSIZE > MAX_SIZE);
  assign rd_go     = accept && !bus.HWRITE && !err;
  assign wr_go     = accept &&  bus.HWRITE && !err;
  assign err_go    = accept && err;
  assign be_full   = gen_be(bus.HSIZE, bus.HADDR[3:0], BE_W);

  rl_ram_1r1w #(
    .DEPTH(MEM_DEPTH), .ABITS(RAW), .DBITS(HDATA_SIZE),
    .TECHNOLOGY(TECHNOLOGY), .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk(HCLK), .waddr(waddr_p1), .wdata(bus.HWDATA), .we(wr_p1), .be(be_p1),
    .raddr(word_addr[RAW-1:0]), .re(rd_go), .rdata(ram_q)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERR2: begin
        if (err_go)                         state_d = ERR1;
        else if (rd_go && WAIT_STATES > 0)  state_d = RWAIT;
        else                                state_d = IDLE;
      end
      RWAIT:   if (cnt_q == 3'd0) state_d = IDLE;
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.HREADYOUT = !(state_q == RWAIT || state_q == ERR1);
    bus.HRESP     = (state_q == ERR1 || state_q == ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q      <= '0;
      wr_p1      <= 1'b0;
      rd_done_p1 <= 1'b0;
      hrdata_q   <= '0;
    end else begin
      wr_p1      <= wr_go;
      rd_done_p1 <= (rd_go && WAIT_STATES == 0) || (state_q == RWAIT && cnt_q == 3'd0);
      if (rd_go && state_q != RWAIT)         cnt_q <= WS_M1;
      else if (state_q == RWAIT && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
      if (rd_done_p1) hrdata_q <= rd_data;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_go) begin
      waddr_p1 <= word_addr[RAW-1:0];
      be_p1    <= be_full[BE_W-1:0];
    end
    if (rd_go) rd_addr_p1 <= word_addr[RAW-1:0];
  end

  // Data phase: write buffer capture; same-word writes merge lanes so forwarding stays exact
  logic         same_word, fwd;
  logic [15:0]  be_p1_ext;
  logic [127:0] buf_merged, rd_merged;

  assign be_p1_ext  = 16'(be_p1);
  assign same_word  = wbuf.valid && (wbuf.addr == 32'(waddr_p1));
  assign buf_merged = merge_bytes(wbuf.data, 128'(bus.HWDATA), be_p1_ext);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) wbuf.valid <= 1'b0;
    else if (wr_p1) begin
      wbuf.valid <= 1'b1;
      wbuf.addr  <= 32'(waddr_p1);
      wbuf.be    <= same_word ? (wbuf.be | be_p1_ext) : be_p1_ext;
      wbuf.data  <= buf_merged;
    end
  end

  // Read completion: RAM word overlaid with buffered lanes of the same word
  assign fwd       = wbuf.valid && (wbuf.addr == 32'(rd_addr_p1));
  assign rd_merged = merge_bytes(128'(ram_q), wbuf.data, fwd ? wbuf.be : 16'h0);
  assign rd_data   = rd_merged[HDATA_SIZE-1:0];
  assign bus.HRDATA = rd_done_p1 ? rd_data : hrdata_q;
endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Directed bench: three slaves (0, 3 and 5 read wait states) on a shared master drive.
module tb_ahb3lite_sram_ws;
  import ahb3lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ahb3lite_sram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) b0 ();
  ahb3lite_sram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) b3 ();
  ahb3lite_sram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) b5 ();

  assign b0.HSEL = sel[0]; assign b3.HSEL = sel[1]; assign b5.HSEL = sel[2];
  assign b0.HADDR = haddr; assign b3.HADDR = haddr; assign b5.HADDR = haddr;
  assign b0.HWDATA = hwdata; assign b3.HWDATA = hwdata; assign b5.HWDATA = hwdata;
  assign b0.HWRITE = hwrite; assign b3.HWRITE = hwrite; assign b5.HWRITE = hwrite;
  assign b0.HSIZE = hsize; assign b3.HSIZE = hsize; assign b5.HSIZE = hsize;
  assign b0.HTRANS = htrans; assign b3.HTRANS = htrans; assign b5.HTRANS = htrans;
  assign b0.HBURST = 3'b000; assign b3.HBURST = 3'b000; assign b5.HBURST = 3'b000;
  assign b0.HPROT = 4'b0011; assign b3.HPROT = 4'b0011; assign b5.HPROT = 4'b0011;
  assign b0.HREADY = b0.HREADYOUT; assign b3.HREADY = b3.HREADYOUT; assign b5.HREADY = b5.HREADYOUT;

  ahb3lite_sram_ws #(.MEM_DEPTH(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(0))
    u_ws0 (.HCLK(clk), .HRESET(rst), .bus(b0));
  ahb3lite_sram_ws #(.MEM_DEPTH(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(3))
    u_ws3 (.HCLK(clk), .HRESET(rst), .bus(b3));
  ahb3lite_sram_ws #(.MEM_DEPTH(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(5))
    u_ws5 (.HCLK(clk), .HRESET(rst), .bus(b5));

  function automatic logic obs_rdy(input int d);
    return (d == 0) ? b0.HREADYOUT : (d == 1) ? b3.HREADYOUT : b5.HREADYOUT;
  endfunction
  function automatic logic obs_resp(input int d);
    return (d == 0) ? b0.HRESP : (d == 1) ? b3.HRESP : b5.HRESP;
  endfunction
  function automatic logic [31:0] obs_rdata(input int d);
    return (d == 0) ? b0.HRDATA : (d == 1) ? b3.HRDATA : b5.HRDATA;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz);
    sel = 3'b001 << d; htrans = HTRANS_NONSEQ; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic drv_idle();
    sel = 3'b000; htrans = HTRANS_IDLE; hwrite = 1'b0;
  endtask

  task automatic wr_word(input int d, input logic [31:0] a, input logic [31:0] v);
    drv(d, 1'b1, a, HSIZE_WORD); step();
    hwdata = v; drv_idle(); step();
  endtask

  // Counts HREADYOUT-low data-phase cycles; returns at the negedge of the completing cycle.
  task automatic rd_wait(input int d, output int lows, output logic [31:0] data);
    bit done;
    done = 1'b0; lows = 0; data = '0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (obs_rdy(d)) begin data = obs_rdata(d); done = 1'b1; end
      else lows++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; drv_idle(); haddr = '0; hwdata = '0; hsize = HSIZE_WORD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({obs_rdy(d), obs_resp(d), obs_rdata(d)} !== {1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL reset_state dut%0d: rdy=%b resp=%b rdata=%h, want rdy=1 resp=0 rdata=0",
                 d, obs_rdy(d), obs_resp(d), obs_rdata(d));
      end
    end
    step(); rst = 1'b0; step();
  endtask

  task automatic test_zero_wait();
    drv(0, 1'b1, 32'h10, HSIZE_WORD); step();
    hwdata = 32'hDEADBEEF; drv(0, 1'b0, 32'h10, HSIZE_WORD);
    @(negedge clk); checks++;
    if (obs_rdy(0) !== 1'b1) begin errors++; $display("FAIL ws0_write_ready: got %b want 1", obs_rdy(0)); end
    step(); drv_idle();
    @(negedge clk); checks++;
    if ({obs_rdy(0), obs_rdata(0)} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL ws0_forward: rdy=%b rdata=%h want rdy=1 rdata=deadbeef", obs_rdy(0), obs_rdata(0));
    end
    step(); @(negedge clk); checks++;
    if (obs_rdata(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL ws0_hold: got %h want deadbeef", obs_rdata(0)); end
    step();
    wr_word(0, 32'h14, 32'h01020304);
    drv(0, 1'b0, 32'h10, HSIZE_WORD); step(); drv_idle();
    @(negedge clk); checks++;
    if (obs_rdata(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL ws0_ram_read: got %h want deadbeef", obs_rdata(0)); end
    step();
  endtask

  task automatic test_byte_merge();
    drv(0, 1'b1, 32'h10, HSIZE_WORD); step();
    hwdata = 32'h11223344; drv(0, 1'b1, 32'h13, HSIZE_BYTE); step();
    hwdata = 32'hAB000000; drv(0, 1'b0, 32'h10, HSIZE_WORD); step(); drv_idle();
    @(negedge clk); checks++;
    if (obs_rdata(0) !== 32'hAB223344) begin errors++; $display("FAIL byte_forward: got %h want ab223344", obs_rdata(0)); end
    step();
    wr_word(0, 32'h14, 32'h01020304);
    drv(0, 1'b1, 32'h16, HSIZE_HWORD); step();
    hwdata = 32'hBEEF0000; drv_idle(); step();
    wr_word(0, 32'h18, 32'h00000000);
    drv(0, 1'b0, 32'h10, HSIZE_WORD); step(); drv_idle();
    @(negedge clk); checks++;
    if (obs_rdata(0) !== 32'hAB223344) begin errors++; $display("FAIL byte_ram: got %h want ab223344", obs_rdata(0)); end
    step();
    drv(0, 1'b0, 32'h14, HSIZE_WORD); step(); drv_idle();
    @(negedge clk); checks++;
    if (obs_rdata(0) !== 32'hBEEF0304) begin errors++; $display("FAIL hword_ram: got %h want beef0304", obs_rdata(0)); end
    step();
  endtask

  task automatic test_addr_error();
    wr_word(0, 32'h00, 32'hCAFEF00D);
    drv(0, 1'b1, 32'h400, HSIZE_WORD); step();
    hwdata = 32'hFFFFFFFF; drv_idle();
    @(negedge clk); checks++;
    if ({obs_rdy(0), obs_resp(0)} !== 2'b01) begin errors++; $display("FAIL addr_err_wr_c1: rdy=%b resp=%b want 0/1", obs_rdy(0), obs_resp(0)); end
    step(); @(negedge clk); checks++;
    if ({obs_rdy(0), obs_resp(0)} !== 2'b11) begin errors++; $display("FAIL addr_err_wr_c2: rdy=%b resp=%b want 1/1", obs_rdy(0), obs_resp(0)); end
    step(); @(negedge clk); checks++;
    if ({obs_rdy(0), obs_resp(0)} !== 2'b10) begin errors++; $display("FAIL addr_err_after: rdy=%b resp=%b want 1/0", obs_rdy(0), obs_resp(0)); end
    step();
    wr_word(0, 32'h08, 32'h55AA55AA);
    drv(0, 1'b0, 32'h00, HSIZE_WORD); step(); drv_idle();
    @(negedge clk); checks++;
    if (obs_rdata(0) !== 32'hCAFEF00D) begin errors++; $display("FAIL addr_err_ram_unchanged: got %h want cafef00d", obs_rdata(0)); end
    step();
    drv(0, 1'b0, 32'h3FC, HSIZE_WORD); step(); drv_idle();
    @(negedge clk); checks++;
    if ({obs_rdy(0), obs_resp(0)} !== 2'b10) begin errors++; $display("FAIL last_word_okay: rdy=%b resp=%b want 1/0", obs_rdy(0), obs_resp(0)); end
    step();
    drv(0, 1'b0, 32'h400, HSIZE_WORD); step(); drv_idle();
    @(negedge clk); checks++;
    if ({obs_rdy(0), obs_resp(0)} !== 2'b01) begin errors++; $display("FAIL addr_err_rd_c1: rdy=%b resp=%b want 0/1", obs_rdy(0), obs_resp(0)); end
    step(); @(negedge clk); checks++;
    if ({obs_rdy(0), obs_resp(0)} !== 2'b11) begin errors++; $display("FAIL addr_err_rd_c2: rdy=%b resp=%b want 1/1", obs_rdy(0), obs_resp(0)); end
    step();
  endtask

  task automatic test_size_error();
    drv(0, 1'b1, 32'h08, HSIZE_DWORD); step();
    hwdata = 32'h00000000; drv_idle();
    @(negedge clk); checks++;
    if ({obs_rdy(0), obs_resp(0)} !== 2'b01) begin errors++; $display("FAIL size_err_c1: rdy=%b resp=%b want 0/1", obs_rdy(0), obs_resp(0)); end
    step();
    drv(0, 1'b0, 32'h08, HSIZE_WORD);
    @(negedge clk); checks++;
    if ({obs_rdy(0), obs_resp(0)} !== 2'b11) begin errors++; $display("FAIL size_err_c2: rdy=%b resp=%b want 1/1", obs_rdy(0), obs_resp(0)); end
    step(); drv_idle();
    @(negedge clk); checks++;
    if ({obs_rdy(0), obs_resp(0), obs_rdata(0)} !== {2'b10, 32'h55AA55AA}) begin
      errors++; $display("FAIL read_in_err2: rdy=%b resp=%b rdata=%h want 1/0/55aa55aa", obs_rdy(0), obs_resp(0), obs_rdata(0));
    end
    step();
  endtask

  task automatic test_wait_states();
    int lows; logic [31:0] data;
    wr_word(1, 32'h20, 32'h12345678);
    wr_word(1, 32'h24, 32'hFFFF0000);
    drv(1, 1'b0, 32'h20, HSIZE_WORD); step(); drv_idle();
    rd_wait(1, lows, data); checks++;
    if (lows !== 3 || data !== 32'h12345678) begin
      errors++; $display("FAIL ws3_read: low_cycles=%0d rdata=%h want 3/12345678", lows, data);
    end
    step(); @(negedge clk); checks++;
    if ({obs_rdy(1), obs_rdata(1)} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL ws3_hold: rdy=%b rdata=%h want 1/12345678", obs_rdy(1), obs_rdata(1));
    end
    step();
    drv(1, 1'b1, 32'h40, HSIZE_WORD); step();
    hwdata = 32'h9ABCDEF0; drv(1, 1'b0, 32'h40, HSIZE_WORD); step(); drv_idle();
    rd_wait(1, lows, data); checks++;
    if (lows !== 3 || data !== 32'h9ABCDEF0) begin
      errors++; $display("FAIL ws3_forward: low_cycles=%0d rdata=%h want 3/9abcdef0", lows, data);
    end
    step();
  endtask

  task automatic test_reset_in_rwait();
    int lows; logic [31:0] data;
    wr_word(2, 32'h20, 32'h0BADC0DE);
    wr_word(2, 32'h28, 32'h77777777);
    drv(2, 1'b0, 32'h20, HSIZE_WORD); step(); drv_idle();
    rd_wait(2, lows, data); checks++;
    if (lows !== 5 || data !== 32'h0BADC0DE) begin
      errors++; $display("FAIL ws5_read: low_cycles=%0d rdata=%h want 5/0badc0de", lows, data);
    end
    step();
    drv(2, 1'b0, 32'h28, HSIZE_WORD); step(); drv_idle();
    @(negedge clk); checks++;
    if (obs_rdy(2) !== 1'b0) begin errors++; $display("FAIL ws5_in_rwait: rdy=%b want 0", obs_rdy(2)); end
    step();
    rst = 1'b1; #1; checks++;
    if ({obs_rdy(2), obs_resp(2), obs_rdata(2)} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL async_reset: rdy=%b resp=%b rdata=%h want 1/0/00000000", obs_rdy(2), obs_resp(2), obs_rdata(2));
    end
    @(posedge clk); #1; rst = 1'b0;
    drv(2, 1'b0, 32'h28, HSIZE_WORD); step(); drv_idle();
    rd_wait(2, lows, data); checks++;
    if (lows !== 5 || data !== 32'h77777777) begin
      errors++; $display("FAIL ws5_after_reset: low_cycles=%0d rdata=%h want 5/77777777", lows, data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_byte_merge();
    test_addr_error();
    test_size_error();
    test_wait_states();
    test_reset_in_rwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
